// File: rtl/pinwheel_data_bus_pkg.sv
// Pinwheel address map: region tags, MMIO offsets and console status bit positions.
package pinwheel_data_bus_pkg;

  localparam logic [3:0] TagBoot = 4'h0;
  localparam logic [3:0] TagRam  = 4'h8;
  localparam logic [3:0] TagHost = 4'hE;
  localparam logic [3:0] TagMmio = 4'hF;

  localparam logic [27:0] OffConTx   = 28'h0;
  localparam logic [27:0] OffConStat = 28'h4;
  localparam logic [27:0] OffTicks   = 28'h8;
  localparam logic [27:0] OffTohost  = 28'hC;

  localparam int unsigned StatFullBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatOvfBit   = 2;
  localparam int unsigned StatCountLsb = 4;

endpackage

// File: rtl/tilelink_pkg.sv
// TileLink-UL channel A/D records and opcodes shared by the pinwheel core and its bus agents.
package tilelink_pkg;

  localparam logic [2:0] TlPutFullData    = 3'd0;
  localparam logic [2:0] TlPutPartialData = 3'd1;
  localparam logic [2:0] TlGet            = 3'd4;

  localparam logic [2:0] TlAccessAck      = 3'd0;
  localparam logic [2:0] TlAccessAckData  = 3'd1;

  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
  } tilelink_a;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [31:0] d_data;
    logic        d_valid;
  } tilelink_d;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/pinwheel_data_bus.sv
// Pinwheel core data bus: byte-lane data RAM, console FIFO, cycle counter and tohost halt latch.
module pinwheel_data_bus
  import tilelink_pkg::*;
  import pinwheel_data_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter int unsigned CON_DEPTH = 16
) (
  input  logic        clock,
  input  logic        tick_reset_n_in,
  input  tilelink_a   tock_bus_tla,
  output tilelink_d   bus_tld,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        tock_con_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(CON_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_rdata_q;
  logic [AW-1:0] ram_idx;

  logic [3:0]  tag;
  logic [27:0] off;
  logic        is_write, sel_ram, sel_mmio, sel_owned;
  logic        addr_err, con_push, con_pop, tohost_we;
  logic [31:0] mmio_rdata, con_stat;
  logic        con_full, con_empty;
  logic [CW-1:0] con_count;

  logic        resp_valid_q, resp_ram_q;
  logic [2:0]  resp_op_q, resp_size_q;
  logic [31:0] resp_data_q, ticks_q, halt_code_q;
  logic        halt_q, bus_err_q, ovf_q;

  assign tag       = tock_bus_tla.a_address[31:28];
  assign off       = tock_bus_tla.a_address[27:0];
  assign ram_idx   = tock_bus_tla.a_address[AW+1:2];
  assign is_write  = (tock_bus_tla.a_opcode == TlPutFullData) ||
                     (tock_bus_tla.a_opcode == TlPutPartialData);
  assign sel_ram   = (tag == TagRam);
  assign sel_mmio  = (tag == TagMmio);
  assign sel_owned = (tag == TagBoot) || (tag == TagHost);

  assign con_stat = (32'(con_count) << StatCountLsb) | (32'(ovf_q) << StatOvfBit) |
                    (32'(con_empty) << StatEmptyBit) | (32'(con_full) << StatFullBit);

  always_comb begin
    mmio_rdata = '0;
    addr_err   = 1'b0;
    con_push   = 1'b0;
    tohost_we  = 1'b0;
    if (sel_mmio) begin
      case (off)
        OffConTx:   con_push   = is_write && tock_bus_tla.a_mask[0];
        OffConStat: mmio_rdata = con_stat;
        OffTicks:   mmio_rdata = ticks_q;
        OffTohost: begin
          mmio_rdata = halt_code_q;
          tohost_we  = is_write;
        end
        default:    addr_err   = 1'b1;
      endcase
    end else if (!sel_ram && !sel_owned) begin
      addr_err = 1'b1;
    end
  end

  // Read-before-write: the registered read sees the word as it was before this edge.
  always_ff @(posedge clock) begin
    ram_rdata_q <= ram[ram_idx];
    if (tick_reset_n_in && sel_ram && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (tock_bus_tla.a_mask[i]) ram[ram_idx][8*i +: 8] <= tock_bus_tla.a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!tick_reset_n_in) begin
      resp_valid_q <= 1'b0;
      resp_ram_q   <= 1'b0;
      resp_op_q    <= '0;
      resp_size_q  <= '0;
      resp_data_q  <= '0;
      ticks_q      <= '0;
      halt_q       <= 1'b0;
      halt_code_q  <= '0;
      bus_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      resp_valid_q <= tock_bus_tla.a_valid;
      resp_ram_q   <= sel_ram;
      resp_op_q    <= is_write ? TlAccessAck : TlAccessAckData;
      resp_size_q  <= tock_bus_tla.a_size;
      resp_data_q  <= is_write ? 32'h0 : mmio_rdata;
      ticks_q      <= ticks_q + 32'd1;
      if (tohost_we && !halt_q) begin
        halt_q      <= 1'b1;
        halt_code_q <= tock_bus_tla.a_data;
      end
      if (addr_err) bus_err_q <= 1'b1;
      if (con_push && con_full && !con_pop) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    bus_tld.d_valid  = resp_valid_q;
    bus_tld.d_opcode = resp_op_q;
    bus_tld.d_size   = resp_size_q;
    bus_tld.d_data   = resp_ram_q ? ram_rdata_q : resp_data_q;
  end

  assign con_valid = !con_empty;
  assign con_pop   = con_valid && tock_con_ready;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign bus_err   = bus_err_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clock     (clock),
    .reset_n   (tick_reset_n_in),
    .push      (con_push),
    .push_data (tock_bus_tla.a_data[7:0]),
    .pop       (con_pop),
    .pop_data  (con_data),
    .full      (con_full),
    .empty     (con_empty),
    .count     (con_count)
  );

endmodule

// File: tb/tb_pinwheel_data_bus.sv
// Scoreboarded bench for pinwheel_data_bus: RAM lanes, console FIFO, TICKS, TOHOST and decode errors.
module tb_pinwheel_data_bus;
  import tilelink_pkg::*;

  logic        clock = 1'b0;
  logic        tick_reset_n_in;
  tilelink_a   tock_bus_tla;
  tilelink_d   bus_tld;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        tock_con_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        bus_err;

  always #5 clock = ~clock;

  pinwheel_data_bus #(
    .RAM_WORDS (4096),
    .CON_DEPTH (16)
  ) dut (
    .clock           (clock),
    .tick_reset_n_in (tick_reset_n_in),
    .tock_bus_tla    (tock_bus_tla),
    .bus_tld         (bus_tld),
    .con_valid       (con_valid),
    .con_data        (con_data),
    .tock_con_ready  (tock_con_ready),
    .halt            (halt),
    .halt_code       (halt_code),
    .bus_err         (bus_err)
  );

  typedef struct {
    string       tag;
    bit          chk_data;
    logic [2:0]  op;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request at the falling edge, then score the response one cycle later.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input bit chk,
                       input logic [31:0] exp, input logic ready = 1'b0);
    exp_t e;
    @(negedge clock);
    tock_bus_tla.a_opcode  = op;
    tock_bus_tla.a_size    = 3'd2;
    tock_bus_tla.a_address = addr;
    tock_bus_tla.a_mask    = mask;
    tock_bus_tla.a_data    = data;
    tock_bus_tla.a_valid   = 1'b1;
    tock_con_ready         = ready;
    e.tag      = tag;
    e.chk_data = chk;
    e.op       = (op == TlGet) ? TlAccessAckData : TlAccessAck;
    e.data     = exp;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_eq({tag, "_valid"}, 32'(bus_tld.d_valid), 32'd1);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_op"}, 32'(bus_tld.d_opcode), 32'(e.op));
      check_eq({e.tag, "_size"}, 32'(bus_tld.d_size), 32'd2);
      if (e.chk_data) check_eq({e.tag, "_data"}, bus_tld.d_data, e.data);
    end
  endtask

  task automatic idle(input string tag, input logic ready = 1'b0);
    issue(tag, TlGet, 32'h0000_0000, 4'hF, 32'h0, 1'b1, 32'h0, ready);
  endtask

  task automatic do_reset();
    @(negedge clock);
    tick_reset_n_in        = 1'b0;
    tock_bus_tla.a_opcode  = TlGet;
    tock_bus_tla.a_address = 32'h0;
    tock_con_ready         = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_d_valid", 32'(bus_tld.d_valid), 32'd0);
    check_eq("rst_d_data", bus_tld.d_data, 32'd0);
    check_eq("rst_halt", 32'(halt), 32'd0);
    check_eq("rst_halt_code", halt_code, 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    check_eq("rst_con_valid", 32'(con_valid), 32'd0);
    sb.delete();
    @(negedge clock);
    tick_reset_n_in = 1'b1;
  endtask

  localparam logic [31:0] ConTx   = 32'hF000_0000;
  localparam logic [31:0] ConStat = 32'hF000_0004;
  localparam logic [31:0] Ticks   = 32'hF000_0008;
  localparam logic [31:0] Tohost  = 32'hF000_000C;

  initial begin
    tick_reset_n_in        = 1'b0;
    tock_con_ready         = 1'b0;
    tock_bus_tla.a_opcode  = TlGet;
    tock_bus_tla.a_size    = 3'd2;
    tock_bus_tla.a_address = 32'h0;
    tock_bus_tla.a_mask    = 4'hF;
    tock_bus_tla.a_data    = 32'h0;
    tock_bus_tla.a_valid   = 1'b1;
    do_reset();

    // Data RAM: full write, partial lane write, aliasing and a second word.
    issue("ram_wr", TlPutFullData, 32'h8000_0004, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
    issue("ram_pwr", TlPutPartialData, 32'h8000_0004, 4'b0010, 32'h0000_AB00, 1'b0, 32'h0);
    issue("ram_rd", TlGet, 32'h8000_0004, 4'hF, 32'h0, 1'b1, 32'h1122_AB44);
    issue("ram_alias", TlGet, 32'h8000_4004, 4'hF, 32'h0, 1'b1, 32'h1122_AB44);
    issue("ram_wr2", TlPutFullData, 32'h8000_0008, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
    issue("ram_rd2", TlGet, 32'h8000_0008, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // Region decode: owned tags read 0 without error, unmapped tags raise bus_err.
    issue("own_e", TlGet, 32'hE000_0000, 4'hF, 32'h0, 1'b1, 32'h0);
    check_eq("own_e_err", 32'(bus_err), 32'd0);
    issue("own_0_wr", TlPutFullData, 32'h0000_0010, 4'hF, 32'h5555_5555, 1'b0, 32'h0);
    issue("own_0_rd", TlGet, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h0);
    check_eq("own_0_err", 32'(bus_err), 32'd0);
    issue("unmap", TlGet, 32'h3000_0000, 4'hF, 32'h0, 1'b1, 32'h0);
    check_eq("unmap_err", 32'(bus_err), 32'd1);
    issue("unmap_sticky", TlGet, 32'hE000_0000, 4'hF, 32'h0, 1'b1, 32'h0);
    check_eq("unmap_err_sticky", 32'(bus_err), 32'd1);
    do_reset();
    issue("mmio_bad", TlGet, 32'hF000_0010, 4'hF, 32'h0, 1'b1, 32'h0);
    check_eq("mmio_bad_err", 32'(bus_err), 32'd1);
    do_reset();

    // TOHOST: first write wins.
    issue("tohost1", TlPutFullData, Tohost, 4'hF, 32'h0000_0001, 1'b0, 32'h0);
    issue("tohost2", TlPutFullData, Tohost, 4'hF, 32'h0000_0002, 1'b0, 32'h0);
    check_eq("halt", 32'(halt), 32'd1);
    check_eq("halt_code", halt_code, 32'h0000_0001);
    issue("tohost_rd", TlGet, Tohost, 4'hF, 32'h0, 1'b1, 32'h0000_0001);
    do_reset();

    // TICKS wrap: counter preloaded, then incremented by the following edge.
    @(negedge clock);
    force dut.ticks_q = 32'hFFFF_FFFE;
    #1;
    release dut.ticks_q;
    issue("ticks0", TlGet, Ticks, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF);
    issue("ticks1", TlGet, Ticks, 4'hF, 32'h0, 1'b1, 32'h0000_0000);
    issue("ticks2", TlGet, Ticks, 4'hF, 32'h0, 1'b1, 32'h0000_0001);

    // Console overflow: 17 writes with the sink stalled.
    check_eq("con_valid_pre", 32'(con_valid), 32'd0);
    for (int i = 0; i < 17; i++) begin
      issue("con_fill", TlPutFullData, ConTx, 4'h1, 32'(8'h10 + i), 1'b0, 32'h0);
      if (i == 0) check_eq("con_valid_rise", 32'(con_valid), 32'd1);
    end
    issue("stat_ovf", TlGet, ConStat, 4'hF, 32'h0, 1'b1, 32'h0000_0105);
    check_eq("con_head_first", 32'(con_data), 32'h10);
    issue("contx_rd", TlGet, ConTx, 4'hF, 32'h0, 1'b1, 32'h0);
    do_reset();

    // Full FIFO with simultaneous enqueue and dequeue.
    for (int i = 0; i < 16; i++) begin
      issue("con_fill2", TlPutFullData, ConTx, 4'h1, 32'(8'h20 + i), 1'b0, 32'h0);
    end
    issue("stat_full", TlGet, ConStat, 4'hF, 32'h0, 1'b1, 32'h0000_0101);
    check_eq("con_head_hold", 32'(con_data), 32'h20);
    issue("con_swap", TlPutFullData, ConTx, 4'h1, 32'h0000_0030, 1'b0, 32'h0, 1'b1);
    check_eq("con_head_adv", 32'(con_data), 32'h21);
    issue("stat_swap", TlGet, ConStat, 4'hF, 32'h0, 1'b1, 32'h0000_0101);

    // Drain and check byte order.
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 32'(con_valid), 32'd1);
      check_eq("drain_data", 32'(con_data), (i < 15) ? 32'(8'h21 + i) : 32'h30);
      idle("drain", 1'b1);
    end
    check_eq("drain_empty", 32'(con_valid), 32'd0);
    issue("stat_empty", TlGet, ConStat, 4'hF, 32'h0, 1'b1, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pinwheel_data_bus.md
PINWHEEL_DATA_BUS -- requirements
Module: pinwheel_data_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, meaning the number of 32-bit data-RAM words (power of two).
REQ-002 SHALL have parameter CON_DEPTH, default 16, meaning the console FIFO depth in bytes (power of two, at least 2).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port tick_reset_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port tock_bus_tla, input, tilelink_a: the core data-bus request, presented every cycle.
REQ-006 SHALL have port bus_tld, output, tilelink_d: the response to the previous cycle's request.
REQ-007 SHALL have port con_valid, output, 1 bit: console byte available.
REQ-008 SHALL have port con_data, output, 8 bits: the console byte at the FIFO head.
REQ-009 SHALL have port tock_con_ready, input, 1 bit: the console sink accepts a byte.
REQ-010 SHALL have port halt, output, 1 bit: sticky, set when tohost is written.
REQ-011 SHALL have port halt_code, output, 32 bits: the value written to tohost.
REQ-012 SHALL have port bus_err, output, 1 bit: sticky, set on an access to an unmapped address.

Function
REQ-013 SHALL decode a_address[31:28]: 0x8 selects the data RAM; 0xF selects MMIO; 0x0 and 0xE are owned elsewhere; all other tags are unmapped.
REQ-014 SHALL treat a request as a write when a_opcode is PutFullData or PutPartialData, and as a read otherwise; a_valid is always 1.
REQ-015 SHALL index the data RAM by a_address[log2(RAM_WORDS)+1:2]; higher address bits below the tag are ignored (the RAM aliases).
REQ-016 SHALL apply RAM writes per byte lane, lane i enabled by a_mask[i].
REQ-017 SHALL return d_data exactly one cycle after the request; a read of a word written in the same cycle SHALL return the old data.
REQ-018 SHALL drive d_valid=1 one cycle after any request; d_opcode SHALL be AccessAckData for reads and AccessAck for writes; d_size SHALL echo the registered a_size.
REQ-019 SHALL read 0 from tags 0x0, 0xE and from unmapped tags, ignore writes to them, and not set bus_err for 0x0 or 0xE.
REQ-020 SHALL implement MMIO at 0xF0000000 CON_TX: a write with a_mask[0]=1 enqueues a_data[7:0]; reads return 0.
REQ-021 SHALL implement MMIO at 0xF0000004 CON_STAT (read-only): bit0 full, bit1 empty, bit2 overflow, bits[12:4] count.
REQ-022 SHALL implement MMIO at 0xF0000008 TICKS (read-only): a free-running 32-bit cycle counter that wraps from 0xFFFFFFFF to 0.
REQ-023 SHALL implement MMIO at 0xF000000C TOHOST: a write sets halt=1 and latches halt_code, with first write wins; reads return halt_code.
REQ-024 SHALL treat any other 0xF offset as unmapped (set bus_err).
REQ-025 SHALL, when the FIFO is full and there is no simultaneous dequeue, drop the enqueue and set sticky overflow.
REQ-026 SHALL dequeue when con_valid && tock_con_ready.
REQ-027 SHALL, on a simultaneous enqueue and dequeue while full, accept both with count unchanged and no overflow.
REQ-028 SHALL not bypass an enqueue to an empty FIFO to the output: con_valid rises the cycle after the write.
REQ-029 SHALL drive con_data from the head entry and hold it stable while con_valid && !tock_con_ready.
REQ-030 SHALL wrap FIFO pointers modulo CON_DEPTH and have count range 0..CON_DEPTH.

Reset
REQ-031 SHALL, while tick_reset_n_in=0 at a clock edge, clear: FIFO pointers and count to 0, overflow, halt, halt_code, bus_err, TICKS, and bus_tld (d_valid=0, d_data=0).
REQ-032 SHALL hold con_valid=0 during and after reset until an enqueue occurs.
REQ-033 SHALL not clear data RAM contents on reset.
REQ-034 SHALL, on reset mid-operation, discard any in-flight response and any FIFO contents.

Structure
REQ-035 SHALL place the address tags, the MMIO offsets and the CON_STAT bit positions in the shared riscv/pinwheel constants package; tilelink_a, tilelink_d and the TL opcodes SHALL come from the existing tilelink package.
REQ-036 SHALL implement the console FIFO as a single sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated once.

Verification
REQ-037 Bench SHALL cover: PutPartialData to 0x80000004 with mask=0010 and data 0x0000AB00 over 0x11223344, then Get -> the response the next cycle reads 0x1122AB44 with AccessAckData.
REQ-038 Bench SHALL cover: 17 writes to CON_TX with tock_con_ready=0 -> CON_STAT reads full=1, overflow=1, count=16; con_data=first byte.
REQ-039 Bench SHALL cover: with the FIFO full, one write to CON_TX plus tock_con_ready=1 in the same cycle -> count stays 16, overflow stays 0, head advances.
REQ-040 Bench SHALL cover: write 0x00000001 then 0x00000002 to TOHOST -> halt=1 and halt_code=0x00000001; a reset clears both.
REQ-041 Bench SHALL cover: preload TICKS to 0xFFFFFFFE via a hierarchical force, run 3 cycles -> reads show the wrap to 0x00000000/0x00000001.
REQ-042 Bench SHALL cover: Get to 0x30000000 -> d_data=0 and bus_err=1; Get to 0xE0000000 -> d_data=0 and bus_err unchanged.
